// File: rtl/clock_period_meter_if.sv
// ----------------------------------------------------------------------------
// clock_period_meter_if
//   Result bundle of clock_period_meter towards the debug/display logic.
//   master : driven by the meter (period, period_valid, timeout, overrun,
//            high_time), samples period_ready.
//   slave  : consumer view, drives period_ready.
// Parameter COUNTER_WIDTH must match the meter instance.
// ----------------------------------------------------------------------------
interface clock_period_meter_if #(
    parameter int COUNTER_WIDTH = 28
);
    logic [COUNTER_WIDTH-1:0] period;
    logic                     period_valid;
    logic                     period_ready;
    logic                     timeout;
    logic                     overrun;
    logic [COUNTER_WIDTH-1:0] high_time;

    modport master (
        output period, period_valid, timeout, overrun, high_time,
        input  period_ready
    );

    modport slave (
        input  period, period_valid, timeout, overrun, high_time,
        output period_ready
    );
endinterface

// File: rtl/clock_period_meter.sv
// ----------------------------------------------------------------------------
// clock_period_meter
//   Measures the period of a slow asynchronous square wave in input_clock
//   cycles. The pin is synchronised, rising edges are detected and the
//   cycles between consecutive rises are delivered on a valid/ready bundle.
//
// Ports
//   input_clock     : fast clock, all logic on its rising edge
//   reset           : synchronous, active-high
//   halt            : freezes counter and FSM; results can still drain
//   measured_signal : asynchronous square wave under test
//   bus (master)    : period / period_valid / period_ready / timeout (sticky)
//                     / overrun (sticky) / high_time
//
// Optional feature macro: MEASURE_HIGH_TIME_EN
//   Defined   : high_time reports the high-phase cycle count of each period.
//   Undefined : high_time is tied to 0.
// ----------------------------------------------------------------------------
module clock_period_meter #(
    parameter int                       COUNTER_WIDTH = 28,
    parameter logic [COUNTER_WIDTH-1:0] TIMEOUT       = COUNTER_WIDTH'(100_000_000),
    parameter int                       SYNC_STAGES   = 2
) (
    input  logic                 input_clock,
    input  logic                 reset,
    input  logic                 halt,
    input  logic                 measured_signal,
    clock_period_meter_if.master bus
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    state_t                   state_reg, state_next;
    logic [SYNC_STAGES-1:0]   sync_reg, sync_next;
    logic                     history_reg;
    logic                     halt_prev_reg;
    logic [COUNTER_WIDTH-1:0] counter_reg, counter_next;
    logic [COUNTER_WIDTH-1:0] period_reg, period_next;
    logic                     valid_reg, valid_next;
    logic                     timeout_reg, timeout_next;
    logic                     overrun_reg, overrun_next;

    logic sync_out, rise, halt_fall;
    logic count_restart, count_clear, count_run;
    logic result_valid, result_load;

    // Synchroniser chain; the last stage feeds the edge-detect history flop.
    assign sync_next[0] = measured_signal;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_next[gi] = sync_reg[gi-1];
    end

    assign sync_out  = sync_reg[SYNC_STAGES-1];
    assign rise      = sync_out & ~history_reg;
    assign halt_fall = halt_prev_reg & ~halt;

    always_ff @(posedge input_clock) begin
        if (reset) begin
            sync_reg      <= '0;
            history_reg   <= 1'b0;
            halt_prev_reg <= 1'b0;
            state_reg     <= IDLE;
            counter_reg   <= '0;
            period_reg    <= '0;
            valid_reg     <= 1'b0;
            timeout_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            sync_reg      <= sync_next;
            history_reg   <= sync_out;
            halt_prev_reg <= halt;
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            period_reg    <= period_next;
            valid_reg     <= valid_next;
            timeout_reg   <= timeout_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Measurement FSM. While halted nothing moves and rises are ignored; the
    // cycle halt drops forces IDLE so no measurement straddles a halt.
    always_comb begin
        state_next    = state_reg;
        timeout_next  = timeout_reg;
        count_restart = 1'b0;
        count_clear   = 1'b0;
        count_run     = 1'b0;
        result_valid  = 1'b0;
        if (halt) begin
            // frozen
        end else if (halt_fall) begin
            state_next  = IDLE;
            count_clear = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        state_next    = MEASURE;
                        timeout_next  = 1'b0;
                        count_restart = 1'b1;
                    end else begin
                        count_clear = 1'b1;
                    end
                end
                MEASURE: begin
                    // A rise beats a coincident timeout.
                    if (rise) begin
                        result_valid  = 1'b1;
                        count_restart = 1'b1;
                    end else if (counter_reg == TIMEOUT) begin
                        timeout_next = 1'b1;
                        state_next   = IDLE;
                        count_clear  = 1'b1;
                    end else begin
                        count_run = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The rise cycle itself counts as the first cycle of the new period.
    always_comb begin
        counter_next = counter_reg;
        if (count_restart) begin
            counter_next = ONE;
        end else if (count_clear) begin
            counter_next = '0;
        end else if (count_run && !(&counter_reg)) begin
            counter_next = counter_reg + ONE;
        end
    end

    // Result handshake: a result only loads into an empty slot or one being
    // drained this very cycle; otherwise it is dropped and flagged.
    always_comb begin
        period_next  = period_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        result_load  = 1'b0;
        if (result_valid) begin
            if (!valid_reg || bus.period_ready) begin
                result_load = 1'b1;
                period_next = counter_reg;
                valid_next  = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (valid_reg && bus.period_ready) begin
            valid_next = 1'b0;
        end
    end

    assign bus.period       = period_reg;
    assign bus.period_valid = valid_reg;
    assign bus.timeout      = timeout_reg;
    assign bus.overrun      = overrun_reg;

`ifdef MEASURE_HIGH_TIME_EN
    logic [COUNTER_WIDTH-1:0] high_cnt_reg, high_cnt_next;
    logic [COUNTER_WIDTH-1:0] high_reg, high_next;

    // Restart at 1: sync_out is necessarily high in the rise cycle.
    always_comb begin
        high_cnt_next = high_cnt_reg;
        high_next     = high_reg;
        if (count_restart) begin
            high_cnt_next = ONE;
        end else if (count_clear) begin
            high_cnt_next = '0;
        end else if (count_run && sync_out && !(&high_cnt_reg)) begin
            high_cnt_next = high_cnt_reg + ONE;
        end
        if (result_load) begin
            high_next = high_cnt_reg;
        end
    end

    always_ff @(posedge input_clock) begin
        if (reset) begin
            high_cnt_reg <= '0;
            high_reg     <= '0;
        end else begin
            high_cnt_reg <= high_cnt_next;
            high_reg     <= high_next;
        end
    end

    assign bus.high_time = high_reg;
`else
    assign bus.high_time = '0;
`endif
endmodule

// File: tb/tb_clock_period_meter.sv
module tb_clock_period_meter;
    localparam int CW   = 28;
    localparam int TO   = 50;
    localparam int SS   = 2;
    localparam int MAXC = 16000;

    logic input_clock = 1'b0;
    logic reset = 1'b1;
    logic halt = 1'b0;
    logic measured_signal = 1'b0;

    clock_period_meter_if #(.COUNTER_WIDTH(CW)) bus();

    clock_period_meter #(
        .COUNTER_WIDTH(CW),
        .TIMEOUT      (28'd50),
        .SYNC_STAGES  (SS)
    ) dut (
        .input_clock    (input_clock),
        .reset          (reset),
        .halt           (halt),
        .measured_signal(measured_signal),
        .bus            (bus.master)
    );

    always #5 input_clock = ~input_clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pin history plus "time since last seen rise".
    bit          pin_hist [MAXC];
    int          cyc = 0;
    int          last_reset = -1;
    bit          m_meas, m_timeout, m_valid, m_overrun, m_halt_prev;
    int          m_last;
    logic [CW-1:0] m_period, m_high;
    int          valid_seen;
    int          phase;

    // Pin value as seen by the edge detector; reset blanks earlier samples.
    function automatic bit dpin(input int i);
        if (i < 0 || i <= last_reset) return 1'b0;
        return pin_hist[i];
    endfunction

    function automatic int highsum(input int a, input int b);
        int s = 0;
        for (int i = a; i < b; i++) s += int'(dpin(i - SS));
        return s;
    endfunction

    task automatic model_step(input bit p, input bit h, input bit rdy, input bit rst);
        bit r, hfall, res;
        int rp, rh;
        res = 1'b0; rp = 0; rh = 0;
        pin_hist[cyc] = p;
        if (rst) begin
            last_reset  = cyc;
            m_meas      = 1'b0; m_timeout = 1'b0; m_valid = 1'b0;
            m_overrun   = 1'b0; m_halt_prev = 1'b0;
            m_period    = '0;   m_high = '0;
        end else begin
            r     = dpin(cyc - SS) && !dpin(cyc - SS - 1);
            hfall = m_halt_prev && !h;
            if (h) begin
            end else if (hfall) begin
                m_meas = 1'b0;
            end else if (!m_meas) begin
                if (r) begin m_meas = 1'b1; m_last = cyc; m_timeout = 1'b0; end
            end else if (r) begin
                res = 1'b1; rp = cyc - m_last; rh = highsum(m_last, cyc); m_last = cyc;
            end else if (cyc - m_last == TO) begin
                m_timeout = 1'b1; m_meas = 1'b0;
            end
            if (m_valid && rdy)
                $display("xfer  cyc=%0d period=%0d high_time=%0d", cyc, m_period, m_high);
            if (res) begin
                if (!m_valid || rdy) begin
                    m_period = CW'(rp); m_high = CW'(rh); m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            m_halt_prev = h;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        logic [CW-1:0] eh;
`ifdef MEASURE_HIGH_TIME_EN
        eh = m_high;
`else
        eh = '0;
`endif
        n_checks++;
        if (bus.period !== m_period || bus.period_valid !== m_valid ||
            bus.timeout !== m_timeout || bus.overrun !== m_overrun || bus.high_time !== eh) begin
            n_fail++;
            $display("FAIL outputs@cyc%0d: got period=%0d valid=%b timeout=%b overrun=%b high=%0d; want period=%0d valid=%b timeout=%b overrun=%b high=%0d",
                     cyc, bus.period, bus.period_valid, bus.timeout, bus.overrun, bus.high_time,
                     m_period, m_valid, m_timeout, m_overrun, eh);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit p, input bit h, input bit rdy, input bit rst);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, want < %0d", cyc, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        @(negedge input_clock);
        measured_signal = p; halt = h; bus.period_ready = rdy; reset = rst;
        @(posedge input_clock);
        model_step(p, h, rdy, rst);
        #1;
        check_outputs();
        if (bus.period_valid === 1'b1) valid_seen++;
    endtask

    task automatic run_wave(input int hi, input int lo, input int n, input bit rdy, input bit h);
        for (int k = 0; k < n; k++) begin
            step((phase % (hi + lo)) < hi, h, rdy, 1'b0);
            phase++;
        end
    endtask

    typedef struct {
        int hi;
        int lo;
        int nper;
        int exp_period;
        int exp_high;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int eh;
        vecs[0] = '{5, 5, 6, 10, 5};
        vecs[1] = '{3, 7, 5, 10, 3};
        vecs[2] = '{10, 10, 4, 20, 10};
        vecs[3] = '{1, 1, 8, 2, 1};
        vecs[4] = '{2, 5, 4, 7, 2};
        vecs[5] = '{5, 5, 4, 10, 5};
        bus.period_ready = 1'b0;

        // Reset state
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("reset_period",   int'(bus.period), 0);
        check_val("reset_valid",    int'(bus.period_valid), 0);
        check_val("reset_timeout",  int'(bus.timeout), 0);
        check_val("reset_overrun",  int'(bus.overrun), 0);
        check_val("reset_high",     int'(bus.high_time), 0);

        // Table-driven steady square waves, ready tied high
        for (int v = 0; v < 6; v++) begin
            phase = 0;
            run_wave(vecs[v].hi, vecs[v].lo, vecs[v].nper * (vecs[v].hi + vecs[v].lo), 1'b1, 1'b0);
`ifdef MEASURE_HIGH_TIME_EN
            eh = vecs[v].exp_high;
`else
            eh = 0;
`endif
            check_val($sformatf("vec%0d_period", v), int'(bus.period), vecs[v].exp_period);
            check_val($sformatf("vec%0d_high", v), int'(bus.high_time), eh);
            check_val($sformatf("vec%0d_overrun", v), int'(bus.overrun), 0);
        end

        // Consumer stalls for three periods -> overrun, value held
        phase = 0;
        run_wave(5, 5, 30, 1'b0, 1'b0);
        check_val("stall_period",  int'(bus.period), 10);
        check_val("stall_valid",   int'(bus.period_valid), 1);
        check_val("stall_overrun", int'(bus.overrun), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("drain_valid", int'(bus.period_valid), 0);

        // Signal held low -> timeout
        for (int k = 0; k < 56; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("timeout_set",   int'(bus.timeout), 1);
        check_val("timeout_valid", int'(bus.period_valid), 0);

        // Resume with a 20-cycle wave
        phase = 0;
        run_wave(10, 10, 3, 1'b1, 1'b0);
        check_val("timeout_clear", int'(bus.timeout), 0);
        run_wave(10, 10, 57, 1'b1, 1'b0);
        check_val("resume_period", int'(bus.period), 20);

        // Halt for 7 cycles mid-period
        phase = 0;
        run_wave(5, 5, 33, 1'b1, 1'b0);
        valid_seen = 0;
        run_wave(5, 5, 7, 1'b1, 1'b1);
        run_wave(5, 5, 12, 1'b1, 1'b0);
        check_val("halt_no_result", valid_seen, 0);
        run_wave(5, 5, 1, 1'b1, 1'b0);
        check_val("halt_after_valid",  int'(bus.period_valid), 1);
        check_val("halt_after_period", int'(bus.period), 10);
        run_wave(5, 5, 14, 1'b1, 1'b0);

        // Reset while a result is pending and the counter is mid-count
        phase = 0;
        run_wave(5, 5, 15, 1'b0, 1'b0);
        check_val("pre_reset_valid", int'(bus.period_valid), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("mid_reset_valid",   int'(bus.period_valid), 0);
        check_val("mid_reset_period",  int'(bus.period), 0);
        check_val("mid_reset_overrun", int'(bus.overrun), 0);
        phase = 0;
        run_wave(5, 5, 40, 1'b1, 1'b0);
        check_val("post_reset_period", int'(bus.period), 10);

        // Randomised traffic against the model
        for (int it = 0; it < 120; it++) begin
            int hi, lo, n, hs, hl;
            bit use_halt;
            hi = $urandom_range(1, 15);
            lo = $urandom_range(1, 15);
            n  = $urandom_range(1, 4) * (hi + lo);
            use_halt = ($urandom_range(0, 9) == 0);
            hs = $urandom_range(0, n - 1);
            hl = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                step((k % (hi + lo)) < hi, use_halt && k >= hs && k < hs + hl,
                     $urandom_range(0, 9) < 7, 1'b0);
            end
            if ($urandom_range(0, 7) == 0) begin
                int quiet;
                quiet = $urandom_range(45, 70);
                for (int k = 0; k < quiet; k++) step(1'b0, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
            end
            if ($urandom_range(0, 14) == 0) step(1'b0, 1'b0, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
